des_round_ctrl: RTL

Iterative DES round engine controller: sequences one shared `f_function` instance through the 16 Feistel rounds of a single 64-bit block, one round per clock. It sits between the initial permutation and the final permutation of the cipher datapath. It takes an IP-permuted block, fetches round keys from an external key-schedule store by index, and returns the pre-output block R16‖L16 for the final permutation. Encrypt and decrypt differ only in the key-index order.

---
 rtl/des_round_ctrl.sv | 128 ++++++++++++
 1 files changed

// File: rtl/des_round_ctrl.sv
// Iterative DES round engine: one shared f-function, one Feistel round per clock.
// Takes an IP-permuted block, returns the pre-output {R16, L16}.
module des_round_ctrl (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [63:0] in_data,
    input  logic        in_decrypt,
    output logic [3:0]  key_idx,
    input  logic [47:0] round_key,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [63:0] out_data,
    output logic        busy
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ROUND = 2'd1,
        S_DONE  = 2'd2
    } state_t;

    // Each S-box is 64 nibbles, row-major, entry 0 in the top nibble
    localparam logic [7:0][255:0] SBOX = {
        256'hE4D12FB83A6C5907_0F74E2D1A6CB9538_41E8D62BFC973A50_FC8249175B3EA06D,
        256'hF18E6B34972DC05A_3D47F28EC01A69B5_0E7BA4D158C6932F_D8A13F42B67C05E9,
        256'hA09E63F51DC7B428_D709346A285ECBF1_D6498F30B12C5AE7_1AD069874FE3B52C,
        256'h7DE3069A1285BC4F_D8B56F03472C1AE9_A690CB7DF13E5284_3F06A1D8945BC72E,
        256'h2C417AB6853FD0E9_EB2C47D150FA3986_421BAD78F9C5630E_B8C71E2D6F09A453,
        256'hC1AF92680D34E75B_AF427C9561DE0B38_9EF528C3704A1DB6_432C95FABE17608D,
        256'h4B2EF08D3C975A61_D0B7491AE35C2F86_14BDC37EAF680592_6BD814A7950FE23C,
        256'hD2846FB1A93E50C7_1FD8A374C56B0E92_7B419CE206ADF358_21E74A8DFC90356B
    };

    state_t      state_q, state_d;
    logic [31:0] l_q, l_d;
    logic [31:0] r_q, r_d;
    logic [3:0]  rnd_q, rnd_d;
    logic        dec_q, dec_d;

    logic [33:0] r_ext;
    logic [5:0]  sx;
    logic [5:0]  sidx;
    logic [31:0] s_out;
    logic [31:0] f_out;

    // E expansion reads overlapping 6-bit windows of R with wrap-around
    always_comb begin
        r_ext = {r_q[0], r_q, r_q[31]};
        s_out = '0;
        sx    = '0;
        sidx  = '0;
        for (int i = 0; i < 8; i++) begin
            sx   = r_ext[33-4*i -: 6] ^ round_key[47-6*i -: 6];
            sidx = {sx[5], sx[0], sx[4:1]};
            s_out[31-4*i -: 4] = SBOX[7-i][{~sidx, 2'b11} -: 4];
        end
    end

    assign f_out = {
        s_out[16], s_out[25], s_out[12], s_out[11],
        s_out[3],  s_out[20], s_out[4],  s_out[15],
        s_out[31], s_out[17], s_out[9],  s_out[6],
        s_out[27], s_out[14], s_out[1],  s_out[22],
        s_out[30], s_out[24], s_out[8],  s_out[18],
        s_out[0],  s_out[5],  s_out[29], s_out[23],
        s_out[13], s_out[19], s_out[2],  s_out[26],
        s_out[10], s_out[21], s_out[28], s_out[7]
    };

    always_comb begin
        state_d = state_q;
        l_d     = l_q;
        r_d     = r_q;
        rnd_d   = rnd_q;
        dec_d   = dec_q;
        case (state_q)
            S_IDLE: begin
                if (in_valid) begin
                    l_d     = in_data[63:32];
                    r_d     = in_data[31:0];
                    dec_d   = in_decrypt;
                    rnd_d   = 4'd0;
                    state_d = S_ROUND;
                end
            end
            S_ROUND: begin
                l_d   = r_q;
                r_d   = l_q ^ f_out;
                rnd_d = rnd_q + 4'd1;
                if (rnd_q == 4'd15) begin
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                if (out_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            l_q     <= '0;
            r_q     <= '0;
            rnd_q   <= '0;
            dec_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            l_q     <= l_d;
            r_q     <= r_d;
            rnd_q   <= rnd_d;
            dec_q   <= dec_d;
        end
    end

    // Decrypt walks the same key store backwards
    assign key_idx   = dec_q ? (4'd15 - rnd_q) : rnd_q;
    assign in_ready  = (state_q == S_IDLE);
    assign out_valid = (state_q == S_DONE);
    assign busy      = (state_q == S_ROUND) || (state_q == S_DONE);
    assign out_data  = {r_q, l_q};

endmodule
